// File: rtl/pcpu_seq_if.sv
// Host-side bus of the pcpu sequencer: program load, run handshake, operand input and run status.
interface pcpu_seq_if #(
    parameter int P_WIDTH        = 32,
    parameter int P_LOG_NREGS    = 2,
    parameter int P_LOG_MEMSIZE  = 4,
    parameter int P_LOG_MAXSTEPS = 8
);
    localparam int P_IW = 1 + 3 + 3 * P_LOG_NREGS + 2 + P_LOG_MEMSIZE;

    logic                      prog_we;
    logic [P_LOG_MEMSIZE-1:0]  prog_addr;
    logic [P_IW-1:0]           prog_data;
    logic                      start;
    logic [P_WIDTH-1:0]        data_in;
    logic                      busy;
    logic                      done;
    logic                      error;
    logic [P_WIDTH-1:0]        result;
    logic [P_LOG_MAXSTEPS-1:0] steps;

    modport master (
        output prog_we, prog_addr, prog_data, start, data_in,
        input  busy, done, error, result, steps
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, start, data_in,
        output busy, done, error, result, steps
    );
endinterface

// File: rtl/pcpu_seq_core.sv
// Microcoded sequencer: one instruction per clock from a writable program memory over a small
// register file, with start/done handshake and a step watchdog.
module pcpu_seq_core #(
    parameter int P_WIDTH        = 32,
    parameter int P_LOG_NREGS    = 2,
    parameter int P_LOG_MEMSIZE  = 4,
    parameter int P_LOG_MAXSTEPS = 8
) (
    input  logic         clk,
    input  logic         rst,
    pcpu_seq_if.slave    bus
);
    localparam int P_IW    = 1 + 3 + 3 * P_LOG_NREGS + 2 + P_LOG_MEMSIZE;
    localparam int NREGS   = 2 ** P_LOG_NREGS;
    localparam int MEMSIZE = 2 ** P_LOG_MEMSIZE;
    localparam logic [P_LOG_MAXSTEPS-1:0] STEP_MAX = '1;

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV, OP_IN, OP_NOP
    } op_t;
    typedef enum logic [1:0] {C_NEVER, C_ALWAYS, C_EQ, C_LT} cond_t;

    typedef struct packed {
        logic                     halt;
        op_t                      op;
        logic [P_LOG_NREGS-1:0]   rd;
        logic [P_LOG_NREGS-1:0]   ra;
        logic [P_LOG_NREGS-1:0]   rb;
        cond_t                    cond;
        logic [P_LOG_MEMSIZE-1:0] target;
    } instr_t;

    state_t                    state, state_nxt;
    logic [P_IW-1:0]           mem  [MEMSIZE];
    logic [P_WIDTH-1:0]        regs [NREGS];
    logic [P_LOG_MEMSIZE-1:0]  pc, pc_nxt;
    logic [P_LOG_MAXSTEPS-1:0] steps;
    logic                      error, done;

    instr_t             instr;
    logic [P_WIDTH-1:0] a, b, wdata;
    logic               wen, taken, exec, finish, abort;

    assign instr = instr_t'(mem[pc]);
    assign a     = regs[instr.ra];
    assign b     = regs[instr.rb];

    // NOTE: every always_comb output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        wdata = '0;
        wen   = 1'b1;
        case (instr.op)
            OP_ADD:  wdata = a + b;
            OP_SUB:  wdata = a - b;
            OP_AND:  wdata = a & b;
            OP_OR:   wdata = a | b;
            OP_XOR:  wdata = a ^ b;
            OP_MOV:  wdata = a;
            OP_IN:   wdata = bus.data_in;
            default: wen   = 1'b0;
        endcase
    end

    // Branch compare sees the pre-writeback register values.
    always_comb begin
        taken = 1'b0;
        case (instr.cond)
            C_ALWAYS: taken = 1'b1;
            C_EQ:     taken = (a == b);
            C_LT:     taken = (a < b);
            default:  taken = 1'b0;
        endcase
    end

    assign pc_nxt = taken ? instr.target : pc + 1'b1;
    assign abort  = !instr.halt && (steps == STEP_MAX);
    assign finish = instr.halt || abort;

    always_comb begin
        state_nxt = state;
        exec      = 1'b0;
        case (state)
            IDLE: if (bus.start) state_nxt = RUN;
            RUN: begin
                exec = 1'b1;
                if (finish) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= '0;
            steps <= '0;
            error <= 1'b0;
            done  <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && bus.start) begin
                pc    <= '0;
                steps <= '0;
                error <= 1'b0;
            end
            if (exec) begin
                if (wen) regs[instr.rd] <= wdata;
                pc <= pc_nxt;
                if (steps != STEP_MAX) steps <= steps + 1'b1;
                if (finish) done  <= 1'b1;
                if (abort)  error <= 1'b1;
            end
        end
    end

    // NOTE: program memory has no reset; the host reloads it and a reset loop would block RAM mapping.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.prog_we) mem[bus.prog_addr] <= bus.prog_data;
    end

    assign bus.busy   = (state == RUN);
    assign bus.done   = done;
    assign bus.error  = error;
    assign bus.result = regs[0];
    assign bus.steps  = steps;
endmodule

// File: tb/tb_pcpu_seq_core.sv
// Directed bench for pcpu_seq_core: add/wrap, GCD, watchdog, pc wrap, ignored mid-run inputs, reset abort.
module tb_pcpu_seq_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    localparam int OP_ADD = 0, OP_SUB = 1, OP_MOV = 5, OP_IN = 6, OP_NOP = 7;
    localparam int C_NEVER = 0, C_ALWAYS = 1, C_EQ = 2, C_LT = 3;

    pcpu_seq_if bus ();

    pcpu_seq_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc(input int h, input int op, input int rd, input int ra,
                                        input int rb, input int c, input int t);
        logic [31:0] vh, vop, vrd, vra, vrb, vc, vt;
        vh = h; vop = op; vrd = rd; vra = ra; vrb = rb; vc = c; vt = t;
        return {vh[0], vop[2:0], vrd[1:0], vra[1:0], vrb[1:0], vc[1:0], vt[3:0]};
    endfunction

    task automatic load(input int addr, input logic [15:0] word);
        @(negedge clk);
        bus.prog_we   = 1'b1;
        bus.prog_addr = addr[3:0];
        bus.prog_data = word;
        @(negedge clk);
        bus.prog_we = 1'b0;
    endtask

    // Counts busy cycles until done; data_in switches to d1 after the first executed instruction.
    task automatic wait_done(input string tag, input logic [31:0] d1, input int budget, output int cyc);
        bit ok;
        cyc = 0;
        ok  = 1'b0;
        while (cyc < budget && !ok) begin
            if (bus.done) ok = 1'b1;
            else begin
                cyc++;
                @(negedge clk);
                if (cyc == 1) bus.data_in = d1;
            end
        end
        check({tag, "_done_seen"}, 64'(ok), 64'd1);
    endtask

    task automatic run(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                       input int budget, output int cyc);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_in = d0;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(tag, d1, budget, cyc);
    endtask

    initial begin
        int  cyc;
        bit  saw_done;
        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        bus.start     = 1'b0;
        bus.data_in   = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy",   64'(bus.busy),   64'd0);
        check("rst_done",   64'(bus.done),   64'd0);
        check("rst_error",  64'(bus.error),  64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_steps",  64'(bus.steps),  64'd0);

        // IN r1; IN r2; ADD r0=r1+r2 halt
        load(0, enc(0, OP_IN, 1, 0, 0, C_NEVER, 0));
        load(1, enc(0, OP_IN, 2, 0, 0, C_NEVER, 0));
        load(2, enc(1, OP_ADD, 0, 1, 2, C_NEVER, 0));
        run("add", 32'd7, 32'd7, 20, cyc);
        check("add_cycles", 64'(cyc),        64'd3);
        check("add_result", 64'(bus.result), 64'd14);
        check("add_steps",  64'(bus.steps),  64'd3);
        check("add_error",  64'(bus.error),  64'd0);
        check("add_busy_at_done", 64'(bus.busy), 64'd0);
        @(negedge clk);
        check("add_done_one_cycle", 64'(bus.done), 64'd0);

        run("wrap_add", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 20, cyc);
        check("wrap_add_result", 64'(bus.result), 64'hFFFF_FFFE);

        // GCD(12,18)
        load(0, enc(0, OP_IN,  0, 0, 0, C_NEVER,  0));
        load(1, enc(0, OP_IN,  1, 0, 0, C_NEVER,  0));
        load(2, enc(0, OP_NOP, 0, 0, 1, C_EQ,     6));
        load(3, enc(0, OP_NOP, 0, 0, 1, C_LT,     5));
        load(4, enc(0, OP_SUB, 0, 0, 1, C_ALWAYS, 2));
        load(5, enc(0, OP_SUB, 1, 1, 0, C_ALWAYS, 2));
        load(6, enc(1, OP_MOV, 0, 0, 0, C_NEVER,  0));
        run("gcd", 32'd12, 32'd18, 100, cyc);
        check("gcd_result", 64'(bus.result), 64'd6);
        check("gcd_error",  64'(bus.error),  64'd0);
        check("gcd_steps",  64'(bus.steps),  64'd10);

        // Watchdog: tight loop at 0
        load(0, enc(0, OP_NOP, 0, 0, 0, C_ALWAYS, 0));
        run("wdog", 32'd0, 32'd0, 400, cyc);
        check("wdog_cycles", 64'(cyc),       64'd256);
        check("wdog_error",  64'(bus.error), 64'd1);
        check("wdog_steps",  64'(bus.steps), 64'd255);
        load(0, enc(1, OP_NOP, 0, 0, 0, C_NEVER, 0));
        run("wdog_clear", 32'd0, 32'd0, 20, cyc);
        check("wdog_clear_error", 64'(bus.error), 64'd0);
        check("wdog_clear_steps", 64'(bus.steps), 64'd1);

        // pc wrap: NOPs at 0..14, halt at 15
        for (int i = 0; i < 15; i++) load(i, enc(0, OP_NOP, 0, 0, 0, C_NEVER, 0));
        load(15, enc(1, OP_NOP, 0, 0, 0, C_NEVER, 0));
        run("pcwrap", 32'd0, 32'd0, 40, cyc);
        check("pcwrap_steps", 64'(bus.steps), 64'd16);

        // Write to 0 together with start: the run must see the new halt word
        @(negedge clk);
        bus.prog_we   = 1'b1;
        bus.prog_addr = 4'd0;
        bus.prog_data = enc(1, OP_NOP, 0, 0, 0, C_NEVER, 0);
        bus.start     = 1'b1;
        @(negedge clk);
        bus.prog_we = 1'b0;
        bus.start   = 1'b0;
        wait_done("simul", bus.data_in, 40, cyc);
        check("simul_steps", 64'(bus.steps), 64'd1);

        // prog_we and start during RUN are ignored
        load(0, enc(0, OP_IN,  0, 0, 0, C_NEVER, 0));
        load(1, enc(0, OP_NOP, 0, 0, 0, C_NEVER, 0));
        load(2, enc(0, OP_NOP, 0, 0, 0, C_NEVER, 0));
        load(3, enc(1, OP_NOP, 0, 0, 0, C_NEVER, 0));
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_in = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.prog_we   = 1'b1;
        bus.prog_addr = 4'd0;
        bus.prog_data = enc(1, OP_NOP, 0, 0, 0, C_NEVER, 0);
        bus.start     = 1'b1;
        @(negedge clk);
        bus.prog_we = 1'b0;
        bus.start   = 1'b0;
        wait_done("midrun", bus.data_in, 40, cyc);
        check("midrun_cycles", 64'(cyc + 2),    64'd4);
        check("midrun_steps",  64'(bus.steps),  64'd4);
        check("midrun_result", 64'(bus.result), 64'd5);
        run("readback", 32'd9, 32'd9, 40, cyc);
        check("readback_steps",  64'(bus.steps),  64'd4);
        check("readback_result", 64'(bus.result), 64'd9);

        // Reset in the middle of an endless loop
        load(0, enc(0, OP_NOP, 0, 0, 0, C_ALWAYS, 0));
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_rst_busy", 64'(bus.busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy",   64'(bus.busy),   64'd0);
        check("midrst_result", 64'(bus.result), 64'd0);
        check("midrst_steps",  64'(bus.steps),  64'd0);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            saw_done = saw_done | bus.done;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            saw_done = saw_done | bus.done | bus.busy;
        end
        check("midrst_no_done", 64'(saw_done), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
